// File: rtl/loas_prefix_matcher.sv
`default_nettype none
// ============================================================================
// Module   : loas_prefix_matcher
// Brief    : Multi-lane handshaked fibre intersection; emits up to LANES
//            matches per beat with dense position, compressed offsets and
//            the B weight. Optional macro LOAS_PREFIX_ACC_EN adds acc_sum.
// Revision : 1.0 - initial release
// ============================================================================
module loas_prefix_matcher #(
    parameter  int BITMASK_WIDTH = 128,
    parameter  int WEIGHT_WIDTH  = 8,
    parameter  int LANES         = 2,
    localparam int PW            = $clog2(BITMASK_WIDTH),
    localparam int ACC_W         = WEIGHT_WIDTH + PW + 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [BITMASK_WIDTH-1:0]              bitmask_a,
    input  logic [BITMASK_WIDTH-1:0]              bitmask_b,
    input  logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] fibre_b_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LANES-1:0]                      out_lane_valid,
    output logic [LANES*PW-1:0]                   out_position,
    output logic [LANES*PW-1:0]                   out_offset_a,
    output logic [LANES*PW-1:0]                   out_offset_b,
    output logic [LANES*WEIGHT_WIDTH-1:0]         out_weight,
    output logic                                  out_last,
    output logic [PW:0]                           match_count
`ifdef LOAS_PREFIX_ACC_EN
    ,
    output logic signed [ACC_W-1:0]               acc_sum
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [BITMASK_WIDTH-1:0]              r_a;
    logic [BITMASK_WIDTH-1:0]              r_b;
    logic [BITMASK_WIDTH-1:0]              r_rem;
    logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] r_data;

    logic                          r_out_valid;
    logic [LANES-1:0]              r_lane_valid;
    logic [LANES*PW-1:0]           r_position;
    logic [LANES*PW-1:0]           r_offset_a;
    logic [LANES*PW-1:0]           r_offset_b;
    logic [LANES*WEIGHT_WIDTH-1:0] r_weight;
    logic                          r_last;
    logic [PW:0]                   r_match_count;

    logic w_accept;
    logic w_load;
    logic w_idle;

    logic [BITMASK_WIDTH-1:0]              w_src_a;
    logic [BITMASK_WIDTH-1:0]              w_src_b;
    logic [BITMASK_WIDTH-1:0]              w_src_rem;
    logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] w_src_data;
    logic [BITMASK_WIDTH-1:0]              w_rem_next;
    logic                                  w_empty;

    logic [LANES-1:0]              w_lv;
    logic [LANES*PW-1:0]           w_pos;
    logic [LANES*PW-1:0]           w_oa;
    logic [LANES*PW-1:0]           w_ob;
    logic [LANES*WEIGHT_WIDTH-1:0] w_w;
    logic [PW:0]                   w_nlanes;

    assign w_idle   = (r_state == ST_IDLE);
    assign in_ready = w_idle;
    assign w_accept = in_valid && w_idle;
    assign w_load   = (r_state == ST_RUN) && (!r_out_valid || out_ready);

    // The first beat is built straight from the ports so it appears the cycle after acceptance.
    assign w_src_a    = w_idle ? bitmask_a : r_a;
    assign w_src_b    = w_idle ? bitmask_b : r_b;
    assign w_src_rem  = w_idle ? (bitmask_a & bitmask_b) : r_rem;
    assign w_src_data = w_idle ? fibre_b_data : r_data;
    assign w_empty    = (w_rem_next == '0);

    always_comb begin : p_extract
        int          lane;
        logic [PW:0] cnt_a;
        logic [PW:0] cnt_b;
        lane       = 0;
        cnt_a      = '0;
        cnt_b      = '0;
        w_lv       = '0;
        w_pos      = '0;
        w_oa       = '0;
        w_ob       = '0;
        w_w        = '0;
        w_rem_next = w_src_rem;
        for (int i = 0; i < BITMASK_WIDTH; i++) begin
            if (w_src_rem[i] && (lane < LANES)) begin
                w_lv[lane]                               = 1'b1;
                w_pos[lane*PW +: PW]                     = PW'(i);
                w_oa[lane*PW +: PW]                      = cnt_a[PW-1:0];
                w_ob[lane*PW +: PW]                      = cnt_b[PW-1:0];
                w_w[lane*WEIGHT_WIDTH +: WEIGHT_WIDTH]   = w_src_data[int'(cnt_b)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                w_rem_next[i]                            = 1'b0;
                lane                                     = lane + 1;
            end
            cnt_a = cnt_a + (PW+1)'(w_src_a[i]);
            cnt_b = cnt_b + (PW+1)'(w_src_b[i]);
        end
        w_nlanes = (PW+1)'(lane);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = w_empty ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (w_load && w_empty) w_state_next = ST_DRAIN;
            ST_DRAIN: if (out_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a           <= '0;
            r_b           <= '0;
            r_rem         <= '0;
            r_data        <= '0;
            r_out_valid   <= 1'b0;
            r_lane_valid  <= '0;
            r_position    <= '0;
            r_offset_a    <= '0;
            r_offset_b    <= '0;
            r_weight      <= '0;
            r_last        <= 1'b0;
            r_match_count <= '0;
        end else begin
            if (w_accept) begin
                r_a    <= bitmask_a;
                r_b    <= bitmask_b;
                r_data <= fibre_b_data;
            end
            if (w_accept || w_load) begin
                r_out_valid   <= 1'b1;
                r_lane_valid  <= w_lv;
                r_position    <= w_pos;
                r_offset_a    <= w_oa;
                r_offset_b    <= w_ob;
                r_weight      <= w_w;
                r_rem         <= w_rem_next;
                r_last        <= w_empty;
                r_match_count <= (w_accept ? '0 : r_match_count) + w_nlanes;
            end else if ((r_state == ST_DRAIN) && out_ready) begin
                r_out_valid <= 1'b0;
                r_last      <= 1'b0;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_lane_valid = r_lane_valid;
    assign out_position   = r_position;
    assign out_offset_a   = r_offset_a;
    assign out_offset_b   = r_offset_b;
    assign out_weight     = r_weight;
    assign out_last       = r_last;
    assign match_count    = r_match_count;

`ifdef LOAS_PREFIX_ACC_EN
    logic signed [ACC_W-1:0] w_beat_sum;
    logic signed [ACC_W-1:0] r_acc;

    always_comb begin
        w_beat_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            if (w_lv[l]) begin
                w_beat_sum = w_beat_sum + ACC_W'($signed(w_w[l*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
            end
        end
    end

    // Acceptance restarts the sum with the first beat's weights.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= w_beat_sum;
        end else if (w_load) begin
            r_acc <= r_acc + w_beat_sum;
        end
    end

    assign acc_sum = r_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_loas_prefix_matcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_loas_prefix_matcher
// Brief    : Self-checking bench for loas_prefix_matcher (16-bit fibres,
//            2 lanes) against a positional reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loas_prefix_matcher;

    localparam int BW  = 16;
    localparam int WW  = 8;
    localparam int L   = 2;
    localparam int PW  = 4;
    localparam int ACC = WW + PW + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BW-1:0]     bitmask_a = '0;
    logic [BW-1:0]     bitmask_b = '0;
    logic [BW*WW-1:0]  fibre_b_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [L-1:0]      out_lane_valid;
    logic [L*PW-1:0]   out_position;
    logic [L*PW-1:0]   out_offset_a;
    logic [L*PW-1:0]   out_offset_b;
    logic [L*WW-1:0]   out_weight;
    logic              out_last;
    logic [PW:0]       match_count;
`ifdef LOAS_PREFIX_ACC_EN
    logic signed [ACC-1:0] acc_sum;
`endif

    loas_prefix_matcher #(.BITMASK_WIDTH(BW), .WEIGHT_WIDTH(WW), .LANES(L)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .bitmask_a(bitmask_a), .bitmask_b(bitmask_b), .fibre_b_data(fibre_b_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
        .out_position(out_position), .out_offset_a(out_offset_a), .out_offset_b(out_offset_b),
        .out_weight(out_weight), .out_last(out_last), .match_count(match_count)
`ifdef LOAS_PREFIX_ACC_EN
        , .acc_sum(acc_sum)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int                    nb;
    logic [L-1:0]          ob_lv  [32];
    logic [L*PW-1:0]       ob_pos [32];
    logic [L*PW-1:0]       ob_oa  [32];
    logic [L*PW-1:0]       ob_ob  [32];
    logic [L*WW-1:0]       ob_w   [32];
    logic                  ob_last[32];
    logic [PW:0]           ob_mc  [32];
    logic signed [ACC-1:0] ob_acc [32];
    int                    stall_bad;
    int                    cyc_used;
    bit                    lat_ok;
    bit                    rdy_after;
    bit                    timed_out;

    // Drives one pair and records every handshaked beat; mode 0 always ready,
    // 1 random ready, 2 ready held low for the first three cycles of beat 1.
    task automatic drive_pair(input logic [BW-1:0] a, input logic [BW-1:0] b,
                              input logic [BW*WW-1:0] d, input int mode);
        int guard;
        int low_cnt;
        bit done;
        bit stalled;
        logic [L+4*L*PW+L*WW+PW+1:0] snap;
        logic [L+4*L*PW+L*WW+PW+1:0] now_v;
        nb = 0; stall_bad = 0; cyc_used = 0; timed_out = 0;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) timed_out = 1;
        bitmask_a = a; bitmask_b = b; fibre_b_data = d; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        bitmask_a = BW'($urandom); bitmask_b = BW'($urandom);
        fibre_b_data = {4{$urandom}};
        lat_ok = out_valid;
        done = 0; stalled = 0; low_cnt = 0; guard = 0; snap = '0;
        while (!done && guard < 200) begin
            now_v = {out_valid, out_lane_valid, out_position, out_offset_a, out_offset_b,
                     out_weight, out_last, match_count};
            if (stalled && now_v !== snap) stall_bad++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (nb > 0) || (low_cnt >= 3);
            endcase
            low_cnt++;
            if (out_valid) cyc_used++;
            if (out_valid && out_ready && nb < 32) begin
                ob_lv[nb] = out_lane_valid; ob_pos[nb] = out_position;
                ob_oa[nb] = out_offset_a;   ob_ob[nb] = out_offset_b;
                ob_w[nb] = out_weight;      ob_last[nb] = out_last;
                ob_mc[nb] = match_count;
`ifdef LOAS_PREFIX_ACC_EN
                ob_acc[nb] = acc_sum;
`else
                ob_acc[nb] = '0;
`endif
                nb++;
                if (out_last) done = 1;
            end
            stalled = out_valid && !out_ready;
            snap = now_v;
            @(negedge clk);
            guard++;
        end
        if (!done) timed_out = 1;
        out_ready = 1'b0;
        rdy_after = in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_lane_valid !== '0) begin errors++; $display("FAIL reset_lane_valid got %b want 0", out_lane_valid); end
        checks++; if ({out_position, out_offset_a, out_offset_b, out_weight} !== '0) begin errors++;
            $display("FAIL reset_lane_fields got %h want 0", {out_position, out_offset_a, out_offset_b, out_weight}); end
        checks++; if (out_last !== 1'b0 || match_count !== '0) begin errors++;
            $display("FAIL reset_last_count got %b/%0d want 0/0", out_last, match_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got %b want 1", in_ready); end
    endtask

    task automatic test_two_beats();
        logic [BW*WW-1:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[k*WW +: WW] = WW'(k + 1);
        drive_pair(16'h00F0, 16'h0FF0, d, 0);
        checks++; if (timed_out || nb !== 2) begin errors++; $display("FAIL two_beats_count got %0d want 2 (timeout=%0d)", nb, timed_out); end
        checks++; if (lat_ok !== 1'b1) begin errors++; $display("FAIL two_beats_latency got %b want 1", lat_ok); end
        checks++; if (cyc_used !== 2) begin errors++; $display("FAIL two_beats_back_to_back got %0d cycles want 2", cyc_used); end
        checks++; if ({ob_lv[0], ob_pos[0], ob_oa[0], ob_ob[0], ob_w[0], ob_last[0]} !== {2'b11, 8'h54, 8'h10, 8'h10, 16'h0201, 1'b0}) begin errors++;
            $display("FAIL two_beats_b0 got %b %h %h %h %h %b want 11 54 10 10 0201 0", ob_lv[0], ob_pos[0], ob_oa[0], ob_ob[0], ob_w[0], ob_last[0]); end
        checks++; if ({ob_lv[1], ob_pos[1], ob_oa[1], ob_ob[1], ob_w[1], ob_last[1]} !== {2'b11, 8'h76, 8'h32, 8'h32, 16'h0403, 1'b1}) begin errors++;
            $display("FAIL two_beats_b1 got %b %h %h %h %h %b want 11 76 32 32 0403 1", ob_lv[1], ob_pos[1], ob_oa[1], ob_ob[1], ob_w[1], ob_last[1]); end
        checks++; if (ob_mc[1] !== 5'd4) begin errors++; $display("FAIL two_beats_match_count got %0d want 4", ob_mc[1]); end
    endtask

    task automatic test_sparse_offsets();
        logic [BW*WW-1:0] d;
        d = '0;
        d[0 +: 8] = 8'd10; d[8 +: 8] = 8'd20; d[16 +: 8] = 8'd30; d[24 +: 8] = 8'd40;
        drive_pair(16'h8001, 16'h8421, d, 0);
        checks++; if (timed_out || nb !== 1) begin errors++; $display("FAIL sparse_count got %0d want 1", nb); end
        checks++; if ({ob_lv[0], ob_pos[0], ob_oa[0], ob_ob[0], ob_w[0], ob_last[0]} !== {2'b11, 8'hF0, 8'h10, 8'h30, 16'h280A, 1'b1}) begin errors++;
            $display("FAIL sparse_b0 got %b %h %h %h %h %b want 11 f0 10 30 280a 1", ob_lv[0], ob_pos[0], ob_oa[0], ob_ob[0], ob_w[0], ob_last[0]); end
        checks++; if (ob_mc[0] !== 5'd2) begin errors++; $display("FAIL sparse_match_count got %0d want 2", ob_mc[0]); end
    endtask

    task automatic test_empty();
        drive_pair(16'h00FF, 16'hFF00, {4{$urandom}}, 0);
        checks++; if (timed_out || nb !== 1) begin errors++; $display("FAIL empty_count got %0d want 1", nb); end
        checks++; if ({ob_lv[0], ob_pos[0], ob_oa[0], ob_ob[0], ob_w[0]} !== '0) begin errors++;
            $display("FAIL empty_lanes got %b %h %h want all 0", ob_lv[0], ob_pos[0], ob_w[0]); end
        checks++; if (ob_last[0] !== 1'b1 || ob_mc[0] !== '0) begin errors++;
            $display("FAIL empty_last_count got %b/%0d want 1/0", ob_last[0], ob_mc[0]); end
        checks++; if (rdy_after !== 1'b1) begin errors++; $display("FAIL empty_in_ready got %b want 1", rdy_after); end
    endtask

    task automatic test_backpressure();
        logic [BW*WW-1:0] d;
        logic [L*PW-1:0]  ep;
        logic [L*WW-1:0]  ew;
        d = {4{$urandom}};
        drive_pair(16'hFFFF, 16'hFFFF, d, 2);
        checks++; if (timed_out || nb !== 8) begin errors++; $display("FAIL bp_count got %0d want 8", nb); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stall_bad); end
        for (int k = 0; k < 8; k++) begin
            ep = {4'(2*k + 1), 4'(2*k)};
            ew = {d[(2*k+1)*WW +: WW], d[2*k*WW +: WW]};
            checks++; if ({ob_lv[k], ob_pos[k], ob_oa[k], ob_ob[k], ob_w[k], ob_last[k]} !== {2'b11, ep, ep, ep, ew, 1'(k == 7)}) begin errors++;
                $display("FAIL bp_beat%0d got %b %h %h %h %h %b want 11 %h %h %h %h %b", k, ob_lv[k], ob_pos[k], ob_oa[k], ob_ob[k], ob_w[k], ob_last[k], ep, ep, ep, ew, k == 7); end
        end
        checks++; if (ob_mc[7] !== 5'd16) begin errors++; $display("FAIL bp_match_count got %0d want 16", ob_mc[7]); end
    endtask

    task automatic test_reset_midrun();
        logic [BW*WW-1:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[k*WW +: WW] = WW'(k + 1);
        @(negedge clk);
        bitmask_a = 16'h00F0; bitmask_b = 16'h0FF0; fibre_b_data = d; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL rst_mid got valid=%b last=%b ready=%b want 0 0 1", out_valid, out_last, in_ready); end
        @(negedge clk);
        rst = 1'b0;
        drive_pair(16'h0003, 16'h0003, d, 0);
        checks++; if (timed_out || nb !== 1) begin errors++; $display("FAIL rst_new_count got %0d want 1", nb); end
        checks++; if ({ob_lv[0], ob_pos[0], ob_w[0], ob_last[0], ob_mc[0]} !== {2'b11, 8'h10, 16'h0201, 1'b1, 5'd2}) begin errors++;
            $display("FAIL rst_new_beat got %b %h %h %b %0d want 11 10 0201 1 2", ob_lv[0], ob_pos[0], ob_w[0], ob_last[0], ob_mc[0]); end
    endtask

    task automatic test_acc();
`ifdef LOAS_PREFIX_ACC_EN
        logic [BW*WW-1:0] d;
        d = '0;
        d[0 +: 8] = -8'sd3; d[8 +: 8] = 8'sd5;
        drive_pair(16'h0003, 16'h0003, d, 0);
        checks++; if (timed_out || ob_last[0] !== 1'b1 || ob_acc[0] !== 13'sd2) begin errors++;
            $display("FAIL acc_sum got %0d want 2", ob_acc[0]); end
`endif
    endtask

    task automatic test_random();
        int               n;
        int               nexp;
        int               idx;
        int               esum;
        int               ep [16];
        int               eoa[16];
        int               eob[16];
        logic [WW-1:0]    ewt[16];
        logic [BW-1:0]    a, b;
        logic [BW*WW-1:0] d;
        logic [L-1:0]     elv;
        logic [L*PW-1:0]  epos, eoav, eobv;
        logic [L*WW-1:0]  ewv;
        for (int t = 0; t < 40; t++) begin
            a = BW'($urandom); b = BW'($urandom);
            if ($urandom_range(0, 1) == 1) a = a & BW'($urandom);
            if ($urandom_range(0, 1) == 1) b = b | BW'($urandom);
            if (t == 0) begin a = 16'hFFFF; b = 16'hFFFF; end
            if (t == 1) begin a = 16'h0000; end
            d = {4{$urandom}};
            n = 0; esum = 0;
            for (int p = 0; p < BW; p++) begin
                if (a[p] && b[p]) begin
                    ep[n]  = p;
                    eoa[n] = $countones(a & ((16'd1 << p) - 16'd1));
                    eob[n] = $countones(b & ((16'd1 << p) - 16'd1));
                    ewt[n] = d[eob[n]*WW +: WW];
                    esum   = esum + int'($signed(ewt[n]));
                    n++;
                end
            end
            nexp = (n == 0) ? 1 : (n + L - 1) / L;
            drive_pair(a, b, d, 1);
            checks++; if (timed_out || nb !== nexp) begin errors++;
                $display("FAIL rand%0d_beats got %0d want %0d (a=%h b=%h)", t, nb, nexp, a, b); end
            checks++; if (stall_bad !== 0 || lat_ok !== 1'b1 || rdy_after !== 1'b1) begin errors++;
                $display("FAIL rand%0d_handshake got stall=%0d lat=%b rdy=%b want 0 1 1", t, stall_bad, lat_ok, rdy_after); end
            for (int k = 0; k < nb && k < nexp; k++) begin
                elv = '0; epos = '0; eoav = '0; eobv = '0; ewv = '0;
                for (int l = 0; l < L; l++) begin
                    idx = k * L + l;
                    if (idx < n) begin
                        elv[l] = 1'b1;
                        epos[l*PW +: PW] = 4'(ep[idx]);
                        eoav[l*PW +: PW] = 4'(eoa[idx]);
                        eobv[l*PW +: PW] = 4'(eob[idx]);
                        ewv[l*WW +: WW]  = ewt[idx];
                    end
                end
                checks++; if ({ob_lv[k], ob_pos[k], ob_oa[k], ob_ob[k], ob_w[k], ob_last[k]} !== {elv, epos, eoav, eobv, ewv, 1'(k == nexp - 1)}) begin errors++;
                    $display("FAIL rand%0d_beat%0d got %b %h %h %h %h %b want %b %h %h %h %h %b", t, k, ob_lv[k], ob_pos[k], ob_oa[k], ob_ob[k], ob_w[k], ob_last[k],
                             elv, epos, eoav, eobv, ewv, k == nexp - 1); end
            end
            if (nb == nexp) begin
                checks++; if (ob_mc[nb-1] !== 5'(n)) begin errors++;
                    $display("FAIL rand%0d_match_count got %0d want %0d", t, ob_mc[nb-1], n); end
`ifdef LOAS_PREFIX_ACC_EN
                checks++; if (ob_acc[nb-1] !== ACC'(esum)) begin errors++;
                    $display("FAIL rand%0d_acc got %0d want %0d", t, ob_acc[nb-1], esum); end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_beats();
        test_sparse_offsets();
        test_empty();
        test_backpressure();
        test_reset_midrun();
        test_acc();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
